// File: rtl/adder_word_seq_pkg.sv
// Shared definitions for the adder_word_seq sequencer.
//   state_t     : sequencer states (IDLE / RUN / DONE)
//   SLICE_W     : width of the shared adder slice
//   calc_nslice : slice count for a word width; 0 flags an unusable width
package adder_word_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SLICE_W = 4;

    // Width must be a whole number of slices and hold at least one slice.
    function automatic int calc_nslice(input int width);
        if (width < SLICE_W || (width % SLICE_W) != 0) begin
            return 0;
        end
        return width / SLICE_W;
    endfunction

endpackage

// File: rtl/adder_word_seq_nibble_adder.sv
// nibble_adder: purely combinational 4-bit ripple-carry adder built from
// four 1-bit full adders.
//   x, y  : slice operands
//   c_in  : carry into bit 0
//   sum   : slice sum
//   c_out : carry out of bit 3
module nibble_adder
    import adder_word_seq_pkg::*;
(
    input  logic [SLICE_W-1:0] x,
    input  logic [SLICE_W-1:0] y,
    input  logic               c_in,
    output logic [SLICE_W-1:0] sum,
    output logic               c_out
);

    logic [SLICE_W:0] carry;

    assign carry[0] = c_in;

    for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
        assign sum[i]       = x[i] ^ y[i] ^ carry[i];
        assign carry[i + 1] = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
    end

    assign c_out = carry[SLICE_W];

endmodule

// File: rtl/adder_word_seq.sv
// adder_word_seq: multi-cycle word adder/subtractor. One 4-bit slice is
// added per clock, least-significant nibble first, through a single shared
// nibble_adder; the carry is held in a register between slices.
//   clk, rst : clock, synchronous active-high reset
//   start    : request, accepted only in IDLE
//   sub      : 0 = a + b + c_in, 1 = a - b (c_in ignored)
//   a, b     : operands, latched on accept
//   c_in     : add carry-in, latched on accept
//   busy     : slices in progress
//   done     : one-cycle pulse, results valid from this cycle on
//   sum      : result, held until the next done
//   c_out    : carry out of the MSB (for subtract, 1 = no borrow)
//   ovf      : two's-complement signed overflow
module adder_word_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    import adder_word_seq_pkg::*;

    localparam int NSLICE = calc_nslice(WIDTH);
    localparam int K_W    = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    if (NSLICE == 0) begin : g_bad_width
        $error("adder_word_seq: WIDTH must be a multiple of 4 and at least 4");
    end

    state_t             state;
    state_t             state_next;

    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_eff;
    logic               carry_reg;
    logic [K_W-1:0]     k;
    logic [WIDTH-1:0]   part;
    logic [WIDTH-1:0]   part_next;

    logic [SLICE_W-1:0] slice_x;
    logic [SLICE_W-1:0] slice_y;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;
    logic               last_slice;

    // ------------------------------------------------------------------
    // Shared slice adder
    // ------------------------------------------------------------------
    assign slice_x    = a_reg[int'(k) * SLICE_W +: SLICE_W];
    assign slice_y    = b_eff[int'(k) * SLICE_W +: SLICE_W];
    assign last_slice = (k == K_W'(NSLICE - 1));

    nibble_adder u_nibble_adder (
        .x     (slice_x),
        .y     (slice_y),
        .c_in  (carry_reg),
        .sum   (slice_sum),
        .c_out (slice_cout)
    );

    // New slices enter at the top so that after NSLICE shifts the first
    // (least-significant) slice has reached bit 0.
    if (NSLICE == 1) begin : g_part_single
        assign part_next = slice_sum;
    end else begin : g_part_shift
        assign part_next = {slice_sum, part[WIDTH-1:SLICE_W]};
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_slice) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg     <= '0;
            b_eff     <= '0;
            carry_reg <= 1'b0;
            k         <= '0;
            part      <= '0;
            sum       <= '0;
            c_out     <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg     <= a;
                        // Subtract is a + ~b + 1: invert b here, inject the +1
                        // as the initial carry.
                        b_eff     <= sub ? ~b : b;
                        carry_reg <= sub ? 1'b1 : c_in;
                        k         <= '0;
                    end
                end
                RUN: begin
                    part      <= part_next;
                    carry_reg <= slice_cout;
                    k         <= k + K_W'(1);
                    if (last_slice) begin
                        sum   <= part_next;
                        c_out <= slice_cout;
                        ovf   <= (a_reg[WIDTH-1] == b_eff[WIDTH-1]) &&
                                 (part_next[WIDTH-1] != a_reg[WIDTH-1]);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_word_seq.sv
// Testbench for adder_word_seq (WIDTH = 16): directed corner cases plus
// randomized operations, each compared against an integer-arithmetic model.
module tb_adder_word_seq;

    localparam int WIDTH  = 16;
    localparam int NSLICE = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;

    int checks   = 0;
    int failures = 0;

    adder_word_seq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    task automatic model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         input logic ci, input logic s,
                         output logic [WIDTH-1:0] r, output logic co, output logic ov);
        longint ux, uy, sx, sy, ur, sr;
        ux = longint'(x);
        uy = longint'(y);
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (s) begin
            ur = ux - uy;
            co = (ux >= uy);
            sr = sx - sy;
        end else begin
            ur = ux + uy + longint'(ci);
            co = (ur >= (longint'(1) << WIDTH));
            sr = sx + sy + longint'(ci);
        end
        r  = ur[WIDTH-1:0];
        ov = (sr > ((longint'(1) << (WIDTH - 1)) - 1)) || (sr < -(longint'(1) << (WIDTH - 1)));
    endtask

    task automatic check_idle_reset(input string tag);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".done"}, done, 0);
        check({tag, ".sum"}, sum, 0);
        check({tag, ".c_out"}, c_out, 0);
        check({tag, ".ovf"}, ovf, 0);
    endtask

    // One operation. glitch_at selects a busy cycle (0-based) in which either
    // a spurious start is pulsed or rst is asserted; -1 means none.
    task automatic do_op(input string tag, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         input logic ci, input logic s, input int glitch_at, input bit glitch_rst);
        logic [WIDTH-1:0] er;
        logic             eco, eov;
        bit               aborted;
        aborted = 1'b0;
        model(x, y, ci, s, er, eco, eov);

        @(negedge clk);
        a = x; b = y; c_in = ci; sub = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = WIDTH'($urandom); b = WIDTH'($urandom); c_in = 1'($urandom); sub = 1'($urandom);

        for (int i = 0; i < NSLICE; i++) begin
            check({tag, ".busy"}, busy, 1);
            check({tag, ".done_early"}, done, 0);
            if (i == glitch_at) begin
                if (glitch_rst) begin
                    rst = 1'b1;
                end else begin
                    start = 1'b1;
                    a = WIDTH'($urandom); b = WIDTH'($urandom); sub = 1'($urandom);
                end
            end
            @(negedge clk);
            rst = 1'b0;
            start = 1'b0;
            if (glitch_rst && i == glitch_at) begin
                aborted = 1'b1;
                break;
            end
        end

        if (aborted) begin
            check_idle_reset({tag, ".abort"});
            for (int j = 0; j < NSLICE + 2; j++) begin
                @(negedge clk);
                check({tag, ".no_done"}, done, 0);
                check({tag, ".no_busy"}, busy, 0);
            end
        end else begin
            check({tag, ".done"}, done, 1);
            check({tag, ".busy_at_done"}, busy, 0);
            check({tag, ".sum"}, sum, 32'(er));
            check({tag, ".c_out"}, c_out, 32'(eco));
            check({tag, ".ovf"}, ovf, 32'(eov));
            @(negedge clk);
            check({tag, ".done_pulse"}, done, 0);
            check({tag, ".sum_hold"}, sum, 32'(er));
            if (glitch_at >= 0) begin
                for (int j = 0; j < NSLICE + 2; j++) begin
                    @(negedge clk);
                    check({tag, ".no_second_done"}, done, 0);
                    check({tag, ".no_second_busy"}, busy, 0);
                end
            end
        end
    endtask

    initial begin
        logic [WIDTH-1:0] rx, ry;
        logic             rc, rs;

        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; c_in = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle_reset("reset");
        end

        do_op("add_1_1_c", 16'h0001, 16'h0001, 1'b1, 1'b0, -1, 1'b0);
        do_op("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, -1, 1'b0);
        do_op("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, -1, 1'b0);
        do_op("sub_borrow",16'h0005, 16'h0007, 1'b0, 1'b1, -1, 1'b0);
        do_op("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, -1, 1'b0);
        do_op("sub_cin_ign",16'h1234, 16'h1234, 1'b1, 1'b1, -1, 1'b0);
        do_op("ign_start", 16'h1234, 16'h4321, 1'b0, 1'b0, 1, 1'b0);
        do_op("mid_reset", 16'hABCD, 16'h1111, 1'b1, 1'b0, 2, 1'b1);
        do_op("after_rst", 16'h00F0, 16'h0F10, 1'b1, 1'b0, -1, 1'b0);

        for (int n = 0; n < 40; n++) begin
            rx = WIDTH'($urandom);
            ry = WIDTH'($urandom);
            rc = 1'($urandom);
            rs = 1'($urandom);
            do_op("random", rx, ry, rc, rs, -1, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
